aes_mixcolumns_fwd_iter: RTL

- Forward (encryption-direction) AES MixColumns engine. It is the counterpart to the existing decryption-side scaling-factor datapath.
- Takes a 128-bit AES state over a valid/ready handshake and mixes one 32-bit column per cycle through a single shared column datapath.
- Returns the mixed state over a second valid/ready handshake.
- Sits between ShiftRows and AddRoundKey in the iterative encryption round.

---
 rtl/aes_ip_pkg.sv | 27 ++
 rtl/aes_mixcolumns_fwd_iter_if.sv | 49 ++++
 rtl/aes_mixcol_column.sv | 35 +++
 rtl/aes_mixcolumns_fwd_iter.sv | 97 +++++++++
 4 files changed

// File: rtl/aes_ip_pkg.sv
// ---------------------------------------------------------------------------
// aes_ip_pkg : shared AES constants, FSM state type and GF(2^8) xtime
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_ip_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_mixcolumns_fwd_iter_if.sv
// ---------------------------------------------------------------------------
// aes_mixcolumns_fwd_iter_if : input/output handshakes of the MixColumns engine
// Optional port in_bypass under AES_MIXCOL_BYPASS_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface aes_mixcolumns_fwd_iter_if;
  import aes_ip_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
`ifdef AES_MIXCOL_BYPASS_EN
  logic               in_bypass;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic               busy;

  modport master (
    output in_valid,
    output in_data,
`ifdef AES_MIXCOL_BYPASS_EN
    output in_bypass,
`endif
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef AES_MIXCOL_BYPASS_EN
    input  in_bypass,
`endif
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/aes_mixcol_column.sv
// ---------------------------------------------------------------------------
// aes_mixcol_column : combinational forward MixColumns on one 32-bit column
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_mixcol_column
  import aes_ip_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [BYTE_W-1:0] x0, x1, x2, x3;

  // Row 0 lives at the MSB end of the column
  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

`default_nettype wire

// File: rtl/aes_mixcolumns_fwd_iter.sv
// ---------------------------------------------------------------------------
// aes_mixcolumns_fwd_iter : iterative forward MixColumns, one column per cycle
// Optional final-round bypass under AES_MIXCOL_BYPASS_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_mixcolumns_fwd_iter
  import aes_ip_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  aes_mixcolumns_fwd_iter_if.slave  bus
);

  mc_state_t          state, state_nxt;
  logic [1:0]         cnt;
  logic [STATE_W-1:0] state_buf;
  logic [COL_W-1:0]   col_in, col_out;
  logic [6:0]         col_lsb;
  logic               accept;
  logic               skip_mix;

  assign accept = bus.in_valid && (state == IDLE);

`ifdef AES_MIXCOL_BYPASS_EN
  assign skip_mix = bus.in_bypass;
`else
  assign skip_mix = 1'b0;
`endif

  // Column c occupies bits [127-32c -: 32]; its LSB is 32*(3-c)
  assign col_lsb = {~cnt, 5'd0};
  assign col_in  = state_buf[col_lsb +: COL_W];

  aes_mixcol_column u_column (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = skip_mix ? DONE : BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (cnt == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = state_buf;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt saturates at 3 inside BUSY; only a fresh load returns it to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      state_buf <= '0;
    end else if (accept) begin
      cnt       <= 2'd0;
      state_buf <= bus.in_data;
    end else if (state == BUSY) begin
      state_buf[col_lsb +: COL_W] <= col_out;
      if (cnt != 2'd3) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

`default_nettype wire
